// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stop levels,
// stall-bit indices, stall patterns, FSM encodings and the priority encoder
// that turns per-stage requests into a stall vector.
package pipe_ctrl_pkg;

   localparam logic        Stop     = 1'b1;
   localparam logic        NoStop   = 1'b0;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // Stall vector bit positions, one per pipeline stage
   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   // Freeze patterns: every stage up to and including the requester stops
   localparam logic [5:0] STALL_PAT_MEM  = 6'b011111;
   localparam logic [5:0] STALL_PAT_EX   = 6'b001111;
   localparam logic [5:0] STALL_PAT_ID   = 6'b000111;
   localparam logic [5:0] STALL_PAT_IF   = 6'b000011;
   localparam logic [5:0] STALL_PAT_NONE = 6'b000000;

   typedef enum logic [1:0] {
      PCTRL_RUN   = 2'd0,
      PCTRL_PEND  = 2'd1,
      PCTRL_FLUSH = 2'd2
   } pctrl_state_e;

   // Highest (latest) stage with a request decides the freeze pattern
   function automatic logic [5:0] stall_pattern(input logic req_if,
                                                input logic req_id,
                                                input logic req_ex,
                                                input logic req_mem);
      logic [5:0] pat;
      if (req_mem)      pat = STALL_PAT_MEM;
      else if (req_ex)  pat = STALL_PAT_EX;
      else if (req_id)  pat = STALL_PAT_ID;
      else if (req_if)  pat = STALL_PAT_IF;
      else              pat = STALL_PAT_NONE;
      return pat;
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for the pipeline controller: cycles each stall source
// wins, and number of redirects that started a flush. Counters wrap.
module pipe_ctrl_perf
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   input  logic        flush_start_i,
   output logic [31:0] perf_stall_if_o,
   output logic [31:0] perf_stall_id_o,
   output logic [31:0] perf_stall_ex_o,
   output logic [31:0] perf_stall_mem_o,
   output logic [31:0] perf_flush_o
);

   logic [31:0] cnt_if_q, cnt_id_q, cnt_ex_q, cnt_mem_q, cnt_flush_q;

   // Decode the winning source from the final pattern and count it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_if_q    <= '0;
         cnt_id_q    <= '0;
         cnt_ex_q    <= '0;
         cnt_mem_q   <= '0;
         cnt_flush_q <= '0;
      end else begin
         if (stall_i == STALL_PAT_IF)  cnt_if_q  <= cnt_if_q + 32'd1;
         if (stall_i == STALL_PAT_ID)  cnt_id_q  <= cnt_id_q + 32'd1;
         if (stall_i == STALL_PAT_EX)  cnt_ex_q  <= cnt_ex_q + 32'd1;
         if (stall_i == STALL_PAT_MEM) cnt_mem_q <= cnt_mem_q + 32'd1;
         if (flush_start_i)            cnt_flush_q <= cnt_flush_q + 32'd1;
      end
   end

   assign perf_stall_if_o  = cnt_if_q;
   assign perf_stall_id_o  = cnt_id_q;
   assign perf_stall_ex_o  = cnt_ex_q;
   assign perf_stall_mem_o = cnt_mem_q;
   assign perf_flush_o     = cnt_flush_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the 6-stage core.
// Merges stage stall requests, sequences redirects into flush pulses
// (deferring them while ex is frozen) and runs a stall watchdog.
// Optional build macro PIPE_CTRL_PERF_EN adds 32-bit performance counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,     // 1..3
   parameter int WDOG_MAX     = 1024,
   parameter int WDOG_W       = 11     // 2**WDOG_W > WDOG_MAX
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   input  logic        wdog_clr,
   output logic        wdog_err
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_if,
   output logic [31:0] perf_stall_id,
   output logic [31:0] perf_stall_ex,
   output logic [31:0] perf_stall_mem,
   output logic [31:0] perf_flush
`endif
);

   localparam logic [1:0]        FLUSH_LOAD = 2'(FLUSH_CYCLES);
   localparam logic [WDOG_W-1:0] WDOG_TERM  = WDOG_W'(WDOG_MAX);
   localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'(WDOG_MAX - 1);

   pctrl_state_e      state_q;
   logic              flush_q;
   logic [31:0]       new_pc_q;
   logic [1:0]        fcnt_q;
   logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic              wdog_err_q, wdog_err_d;
   logic [5:0]        stall_vec;

   // Final stall vector: flush squashes the front end, but a mem stall must
   // still freeze everything; reset holds the vector at zero.
   always_comb begin
      stall_vec = stall_pattern(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
      if (!rst)
         stall_vec = STALL_PAT_NONE;
      else if (flush_q && !stallreq_mem)
         stall_vec = STALL_PAT_NONE;
   end

   // Redirect sequencer: accept, defer while ex is frozen, then flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= PCTRL_RUN;
         flush_q  <= 1'b0;
         new_pc_q <= ZeroWord;
         fcnt_q   <= 2'd0;
      end else begin
         case (state_q)
            PCTRL_RUN: begin
               if (branch_flag) begin
                  new_pc_q <= branch_target;
                  if (stall_vec[STALL_EX] == NoStop) begin
                     state_q <= PCTRL_FLUSH;
                     flush_q <= 1'b1;
                     fcnt_q  <= FLUSH_LOAD;
                  end else begin
                     state_q <= PCTRL_PEND;
                  end
               end
            end
            PCTRL_PEND: begin
               // Repeated branch_flag here is the same frozen instruction
               if (stall_vec[STALL_EX] == NoStop) begin
                  state_q <= PCTRL_FLUSH;
                  flush_q <= 1'b1;
                  fcnt_q  <= FLUSH_LOAD;
               end
            end
            PCTRL_FLUSH: begin
               // branch_flag here comes from a squashed instruction
               if (fcnt_q == 2'd1) begin
                  state_q <= PCTRL_RUN;
                  flush_q <= 1'b0;
                  fcnt_q  <= 2'd0;
               end else begin
                  fcnt_q <= fcnt_q - 2'd1;
               end
            end
            default: begin
               state_q <= PCTRL_RUN;
               flush_q <= 1'b0;
               fcnt_q  <= 2'd0;
            end
         endcase
      end
   end

   // Watchdog next state: count consecutive stalled cycles, saturate at the
   // terminal count and set the sticky flag; clear has priority.
   always_comb begin
      wdog_cnt_d = wdog_cnt_q;
      wdog_err_d = wdog_err_q;
      if (wdog_clr) begin
         wdog_cnt_d = '0;
         wdog_err_d = 1'b0;
      end else if (stall_vec == STALL_PAT_NONE) begin
         wdog_cnt_d = '0;
      end else if (wdog_cnt_q != WDOG_TERM) begin
         wdog_cnt_d = wdog_cnt_q + 1'b1;
         if (wdog_cnt_q == WDOG_LAST)
            wdog_err_d = 1'b1;
      end
   end

   // Watchdog registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign stall    = stall_vec;
   assign flush    = flush_q;
   assign new_pc   = new_pc_q;
   assign wdog_err = wdog_err_q;

`ifdef PIPE_CTRL_PERF_EN
   logic flush_start;

   // A redirect is accepted when the FSM is about to enter FLUSH
   always_comb begin
      flush_start = 1'b0;
      if (rst && stall_vec[STALL_EX] == NoStop) begin
         if (state_q == PCTRL_PEND)
            flush_start = 1'b1;
         else if (state_q == PCTRL_RUN && branch_flag)
            flush_start = 1'b1;
      end
   end

   pipe_ctrl_perf u_perf (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_vec),
      .flush_start_i    (flush_start),
      .perf_stall_if_o  (perf_stall_if),
      .perf_stall_id_o  (perf_stall_id),
      .perf_stall_ex_o  (perf_stall_ex),
      .perf_stall_mem_o (perf_stall_mem),
      .perf_flush_o     (perf_flush)
   );
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline stall/flush controller for the 6-stage RISC-V core (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the `stall[5:0]` vector consumed by every pipeline register.
- Sequences branch/jump redirects into flush pulses, and defers a redirect while the ex stage is frozen.
- Runs a stall watchdog that flags a hung pipeline.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles `flush` stays asserted per redirect (1..3).
- WDOG_MAX, 1024, consecutive stalled cycles before `wdog_err` sets.
- WDOG_W, 11, watchdog counter width; must satisfy 2^WDOG_W > WDOG_MAX.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-low.
- stallreq_if  in  1  fetch waiting on instruction memory.
- stallreq_id  in  1  load-use hazard detected in decode.
- stallreq_ex  in  1  multi-cycle ex operation busy.
- stallreq_mem  in  1  data memory access busy.
- branch_flag  in  1  ex resolved a taken branch/jump this cycle.
- branch_target  in  32  redirect PC, valid with `branch_flag`.
- stall  out  6  per-stage freeze, bit0=pc … bit5=wb, `Stop`=1.
- flush  out  1  squash if_id and id_ex contents.
- new_pc  out  32  redirect address for the pc register, valid while `flush`=1.
- wdog_err  out  1  sticky watchdog flag.
- wdog_clr  in  1  clears `wdog_err` and the watchdog counter.

Behaviour:
- Reset (rst=0, async): `stall`=6'b0, `flush`=0, `new_pc`=`ZeroWord`, `wdog_err`=0, FSM=RUN, pending=0, all counters 0.
- Stall vector, combinational from requests, highest stage wins:
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else if → 6'b000011
  - else 6'b000000
- The `stall` pattern guarantees exactly one register (the boundary with stall[k]=Stop, stall[k+1]=NoStop) inserts a bubble.
- `stall` is forced to 6'b0 while `flush`=1, except a mem request, which still yields 6'b011111.
- FSM states: RUN, PEND, FLUSH.
  - RUN: `branch_flag`=1 with stall[3]=NoStop → latch `branch_target` into `new_pc`, load flush counter with FLUSH_CYCLES, go to FLUSH.
  - RUN: `branch_flag`=1 with stall[3]=Stop → latch target, go to PEND.
  - PEND: hold the target. First cycle with stall[3]=NoStop → go to FLUSH. Further `branch_flag` pulses in PEND are ignored (ex is frozen, so they are duplicates).
  - FLUSH: `flush`=1, counter decrements each cycle. At counter=1 → go to RUN. `branch_flag` in FLUSH is ignored, because the squashed instruction cannot be valid.
- `flush` and `new_pc` are registered: `flush` rises the cycle after acceptance.
- Redirect latency from `branch_flag` (unstalled) to `flush`=1 is one cycle.
- Watchdog:
  - Counter increments while stall≠0.
  - Counter clears on any cycle with stall==0, or on `wdog_clr`.
  - When the counter reaches WDOG_MAX, `wdog_err` sets and the counter saturates.
  - `wdog_err` clears only on `wdog_clr` or reset.
  - `wdog_clr` and the terminal count in the same cycle → clear wins.
- Reset asserted mid-FLUSH or mid-PEND → immediate return to RUN, with the pending target discarded.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs `perf_stall_if`, `perf_stall_id`, `perf_stall_ex`, `perf_stall_mem`, `perf_flush`, all 32-bit.
  - Each stall counter counts cycles in which that source is the winning request.
  - `perf_flush` counts accepted redirects.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared include (`define.v`) gains:
  - `Stop`/`NoStop`
  - stall-bit indices `STALL_PC`..`STALL_WB`
  - the four stall pattern constants
  - FSM state encodings `PCTRL_RUN`/`PCTRL_PEND`/`PCTRL_FLUSH` (2-bit)
- One sub-module, `pipe_ctrl_perf`, holds the optional counters and is instantiated only under PIPE_CTRL_PERF_EN.

Test Plan:
- Requests id=1 and mem=1 together → `stall`=6'b011111. Drop mem → 6'b000111 in the same cycle.
- `branch_flag`=1, target 0x0000_1040, no stall → next cycle `flush`=1, `new_pc`=0x0000_1040 for exactly FLUSH_CYCLES cycles, then `flush`=0.
- `branch_flag` with ex stalled for 3 cycles → FSM in PEND, `flush` stays 0. `flush`=1 one cycle after the stall drops, with the original target.
- Second `branch_flag` (target 0x2000) during FLUSH → ignored; `new_pc` stays 0x1040 and `flush` length is unchanged.
- Hold `stallreq_mem`=1 for WDOG_MAX=1024 cycles → `wdog_err`=1 and stays 1 after release. `wdog_clr` pulse → `wdog_err`=0.
- Assert rst=0 asynchronously mid-FLUSH → `flush`=0, `new_pc`=0 and `stall`=0 immediately, without waiting for a clock edge.
